updown_counter_param: RTL

- Parametrised up/down counter; successor to the fixed 4-bit up/down counter.
- Adds programmable width and terminal value, variable step, synchronous load and count enable.
- Supports wrap or saturate mode, and registered overflow/underflow event flags.
- Used as a general timebase/position counter in later designs.

---
 rtl/updown_counter_param.sv | 137 +++++++++++++
 1 files changed

// File: rtl/updown_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_param
// Description : Parametrised up/down counter with programmable width, terminal
//               value, variable step, synchronous load and count enable.
//               Wraps modulo (MAX_VAL+1) or saturates at the count-range
//               limits, and raises registered one-cycle overflow/underflow
//               event flags.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous active-low reset
//   en        in   1      count enable
//   upordown  in   1      direction: 1 = up, 0 = down
//   step      in   WIDTH  amount added/subtracted per enabled cycle
//   load      in   1      synchronous load strobe (highest priority)
//   load_val  in   WIDTH  value loaded (clamped to MAX_VAL) when load=1
//   count     out  WIDTH  registered counter value, always in 0..MAX_VAL
//   ovf       out  1      registered pulse: up count passed MAX_VAL
//   unf       out  1      registered pulse: down count passed 0
//   at_max    out  1      count == MAX_VAL (combinational from count)
//   at_zero   out  1      count == 0 (combinational from count)
// ============================================================================
module updown_counter_param #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 255,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             upordown,
    input  logic [WIDTH-1:0] step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             unf,
    output logic             at_max,
    output logic             at_zero
);

    // Terminal value in the native width and in the one-bit-wider
    // arithmetic domain; the modulus MAX_VAL+1 can reach 2**WIDTH, which
    // only fits in the wider domain.
    localparam logic [WIDTH-1:0] c_MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH:0]   c_MAX_X = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   c_MOD_X = c_MAX_X + (WIDTH+1)'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH-1:0] w_step_eff;   // step clamped to MAX_VAL
    logic [WIDTH-1:0] w_load_eff;   // load_val clamped to MAX_VAL
    logic [WIDTH:0]   w_cnt_x;
    logic [WIDTH:0]   w_step_x;
    logic [WIDTH:0]   w_sum_x;      // count + s, never truncated
    logic [WIDTH-1:0] w_up_wrap;    // count + s - (MAX_VAL+1)
    logic [WIDTH-1:0] w_dn_diff;    // count - s (valid when count >= s)
    logic [WIDTH-1:0] w_dn_wrap;    // count + (MAX_VAL+1) - s

    // ------------------------------------------------------------------
    // Datapath: all candidate results are formed in parallel; the
    // next-state logic below only selects among them.
    // ------------------------------------------------------------------
    always_comb begin
        w_step_eff = (step > c_MAX_W) ? c_MAX_W : step;
        w_load_eff = (load_val > c_MAX_W) ? c_MAX_W : load_val;
        w_cnt_x    = {1'b0, count_q};
        w_step_x   = {1'b0, w_step_eff};
        w_sum_x    = w_cnt_x + w_step_x;
        // Only used when count + s > MAX_VAL, so the result is in range.
        w_up_wrap  = WIDTH'(w_sum_x - c_MOD_X);
        w_dn_diff  = WIDTH'(w_cnt_x - w_step_x);
        // Only used when count < s <= MAX_VAL, so count+MOD-s < MOD.
        w_dn_wrap  = WIDTH'(w_cnt_x + c_MOD_X - w_step_x);
    end

    // ------------------------------------------------------------------
    // Next-state selection. Priority: load > en > hold. Event flags
    // default low so they are cleared on every edge without a boundary
    // event, which also guarantees ovf and unf are never both high.
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (load) begin
            count_d = w_load_eff;
        end else if (en) begin
            if (upordown) begin
                if (w_sum_x <= c_MAX_X) begin
                    count_d = w_sum_x[WIDTH-1:0];
                end else if (SATURATE) begin
                    count_d = c_MAX_W;
                    // Already pinned at the limit: no new event.
                    ovf_d   = (count_q != c_MAX_W);
                end else begin
                    count_d = w_up_wrap;
                    ovf_d   = 1'b1;
                end
            end else begin
                if (count_q >= w_step_eff) begin
                    count_d = w_dn_diff;
                end else if (SATURATE) begin
                    count_d = '0;
                    unf_d   = (count_q != '0);
                end else begin
                    count_d = w_dn_wrap;
                    unf_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count   = count_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;
    assign at_max  = (count_q == c_MAX_W);
    assign at_zero = (count_q == '0);

endmodule
`default_nettype wire
